dual_alu_io_responder: RTL

DUAL_ALU_IO_RESPONDER -- requirements
Module: dual_alu_io_responder

---
 rtl/dual_alu_io_responder.sv | 120 ++++++++++++
 1 files changed

// File: rtl/dual_alu_io_responder.sv
// Dual 4-bit ALU behind a pad interface: a debounced input word is
// accepted once stable, evaluated by two ALUs and published on res_o.
module dual_alu_io_responder #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [19:0] in_word_i,
    output logic [14:0] res_o,
    output logic [14:0] io_oeb_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        EXEC
    } state_t;

    localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

    state_t      state;
    state_t      state_nx;
    logic [19:0] sync1;
    logic [19:0] sw;
    logic [19:0] ps;
    logic [19:0] acc_word;
    logic [3:0]  stab_cnt;
    logic [3:0]  stab_nx;
    logic        first_flag;
    logic        accept;
    logic [3:0]  upd_cnt;
    logic [4:0]  r0;
    logic [4:0]  r1;

    function automatic logic [4:0] alu(
        input logic [1:0] sel,
        input logic [3:0] a,
        input logic [3:0] b
    );
        logic [4:0] r;
        case (sel)
            2'b00:   r = {1'b0, a} + {1'b0, b};
            2'b01:   r = {1'b0, a} - {1'b0, b};
            2'b10:   r = {1'b0, a & b};
            default: r = {1'b0, a ^ b};
        endcase
        return r;
    endfunction

    assign upd_cnt = res_o[13:10];
    assign r0 = alu(acc_word[17:16], acc_word[3:0], acc_word[7:4]);
    assign r1 = alu(acc_word[19:18], acc_word[11:8], acc_word[15:12]);

    always_comb begin
        stab_nx = stab_cnt;
        if (sw != ps)
            stab_nx = 4'd0;
        else if (stab_cnt != STABLE)
            stab_nx = stab_cnt + 4'd1;
    end

    // Acceptance fires on the edge where the stability count reaches
    // its target, so the word is latched without an extra wait cycle.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                if (first_flag || sw != acc_word)
                    state_nx = SETTLE;
            end
            SETTLE: begin
                if (!first_flag && sw == acc_word) begin
                    state_nx = IDLE;
                end else if (stab_nx == STABLE) begin
                    state_nx = EXEC;
                    accept   = 1'b1;
                end
            end
            EXEC: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // The IDLE cycle that has already seen a new word counts as busy.
    assign busy_o = (state != IDLE) || (!first_flag && sw != acc_word);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync1      <= '0;
            sw         <= '0;
            ps         <= '0;
            stab_cnt   <= '0;
            acc_word   <= '0;
            first_flag <= 1'b1;
            state      <= IDLE;
            res_o      <= '0;
            io_oeb_o   <= '1;
        end else begin
            sync1    <= in_word_i;
            sw       <= sync1;
            ps       <= sw;
            stab_cnt <= stab_nx;
            state    <= state_nx;
            io_oeb_o <= '0;
            if (accept) begin
                acc_word   <= sw;
                first_flag <= 1'b0;
            end
            if (state == EXEC)
                res_o <= {1'b1, upd_cnt + 4'd1, r1, r0};
        end
    end

endmodule
